// File: rtl/sfx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sfx_pkg: shared types and default sizes for the sound-effect mixer.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sfx_pkg;

  localparam int c_N_REQ    = 4;
  localparam int c_SAMPLE_W = 24;
  localparam int c_DUR_W    = 16;

  localparam logic [c_SAMPLE_W-1:0] c_ZERO_SAMPLE = '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_RELEASE = 2'd2
  } sfx_state_t;

endpackage
`default_nettype wire

// File: rtl/sfx_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sfx_scheduler_if: requester/codec-side bundle of the scheduler.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sfx_scheduler_if
  import sfx_pkg::*;
#(
  parameter int N_REQ    = c_N_REQ,
  parameter int SAMPLE_W = c_SAMPLE_W,
  parameter int DUR_W    = c_DUR_W
);

  logic [N_REQ-1:0]          req;
  logic [N_REQ*DUR_W-1:0]    req_dur;
  logic [N_REQ*SAMPLE_W-1:0] src_sample;
  logic [N_REQ-1:0]          ack;
  logic [N_REQ-1:0]          grant;
  logic                      gate;
  logic [SAMPLE_W-1:0]       out_sample;
  logic                      out_valid;
  logic                      busy;
  logic                      done;

  modport master (
    output req, req_dur, src_sample,
    input  ack, grant, gate, out_sample, out_valid, busy, done
  );

  modport slave (
    input  req, req_dur, src_sample,
    output ack, grant, gate, out_sample, out_valid, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/sfx_prio_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sfx_prio_pick: combinational lowest-index-wins one-hot picker.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sfx_prio_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scan from the top so the lowest set index is the last (winning) write.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_idx       = IDX_W'(i);
        o_valid     = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sfx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sfx_scheduler: fixed-priority owner of the shared sample path, paced |
// | by sample_tick. Optional preemption under SFX_PREEMPT_EN.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int N_REQ    = c_N_REQ,
  parameter int SAMPLE_W = c_SAMPLE_W,
  parameter int DUR_W    = c_DUR_W
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           sample_tick,
  sfx_scheduler_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [SAMPLE_W-1:0] c_ZERO    = SAMPLE_W'(c_ZERO_SAMPLE);
  localparam logic [DUR_W-1:0]    c_DUR_ONE = DUR_W'(1);

  sfx_state_t          r_state;
  logic [DUR_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [N_REQ-1:0]    r_grant;
  logic [N_REQ-1:0]    r_ack;
  logic                r_gate;
  logic                r_out_valid;
  logic                r_done;
  logic [SAMPLE_W-1:0] r_out_sample;

  logic [N_REQ-1:0]    w_idle_onehot;
  logic [IDX_W-1:0]    w_idle_idx;
  logic                w_idle_valid;
  logic [DUR_W-1:0]    w_idle_load;
  logic [SAMPLE_W-1:0] w_own_sample;

  logic [N_REQ-1:0]    w_pre_onehot;
  logic [IDX_W-1:0]    w_pre_idx;
  logic                w_pre_valid;
  logic [DUR_W-1:0]    w_pre_load;
  logic [SAMPLE_W-1:0] w_pre_sample;

  function automatic logic [DUR_W-1:0] f_load(input logic [DUR_W-1:0] dur);
    return (dur == '0) ? c_DUR_ONE : dur;
  endfunction

  sfx_prio_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick_idle (
    .i_req    (bus.req),
    .o_onehot (w_idle_onehot),
    .o_idx    (w_idle_idx),
    .o_valid  (w_idle_valid)
  );

  assign w_idle_load  = f_load(bus.req_dur[int'(w_idle_idx)*DUR_W +: DUR_W]);
  assign w_own_sample = bus.src_sample[int'(r_idx)*SAMPLE_W +: SAMPLE_W];

`ifdef SFX_PREEMPT_EN
  logic [N_REQ-1:0] w_pre_req;

  // Grant minus one leaves exactly the indices that outrank the owner.
  assign w_pre_req = bus.req & (r_grant - N_REQ'(1));

  sfx_prio_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick_pre (
    .i_req    (w_pre_req),
    .o_onehot (w_pre_onehot),
    .o_idx    (w_pre_idx),
    .o_valid  (w_pre_valid)
  );

  assign w_pre_load   = f_load(bus.req_dur[int'(w_pre_idx)*DUR_W +: DUR_W]);
  assign w_pre_sample = bus.src_sample[int'(w_pre_idx)*SAMPLE_W +: SAMPLE_W];
`else
  assign w_pre_onehot = '0;
  assign w_pre_idx    = '0;
  assign w_pre_valid  = 1'b0;
  assign w_pre_load   = c_DUR_ONE;
  assign w_pre_sample = c_ZERO;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_grant      <= '0;
      r_ack        <= '0;
      r_gate       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_done       <= 1'b0;
      r_out_sample <= c_ZERO;
    end else begin
      r_ack       <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_out_sample <= c_ZERO;
          if (w_idle_valid) begin
            r_state <= ST_PLAY;
            r_grant <= w_idle_onehot;
            r_ack   <= w_idle_onehot;
            r_idx   <= w_idle_idx;
            r_cnt   <= w_idle_load;
            r_gate  <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (sample_tick) begin
            r_out_valid <= 1'b1;
            if (w_pre_valid) begin
              // The preempting effect's first sample goes out on this tick,
              // so it is already one sample into its duration.
              r_out_sample <= w_pre_sample;
              r_grant      <= w_pre_onehot;
              r_ack        <= w_pre_onehot;
              r_idx        <= w_pre_idx;
              r_done       <= 1'b1;
              r_cnt        <= w_pre_load - c_DUR_ONE;
              if (w_pre_load == c_DUR_ONE) begin
                r_state <= ST_RELEASE;
              end
            end else begin
              r_out_sample <= w_own_sample;
              r_cnt        <= r_cnt - c_DUR_ONE;
              if (r_cnt == c_DUR_ONE) begin
                r_state <= ST_RELEASE;
              end
            end
          end
        end
        ST_RELEASE: begin
          if (sample_tick) begin
            r_out_sample <= c_ZERO;
            r_out_valid  <= 1'b1;
            r_done       <= 1'b1;
            r_grant      <= '0;
            r_gate       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack        = r_ack;
  assign bus.grant      = r_grant;
  assign bus.gate       = r_gate;
  assign bus.out_sample = r_out_sample;
  assign bus.out_valid  = r_out_valid;
  assign bus.done       = r_done;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
